alu_byte_arbiter: RTL
=====================

# alu_byte_arbiter

Round-robin arbiter that shares the ALU's single byte-wide operand path between eight requesters. It selects one requester per transfer and drives the 3-bit source select onto the 8:1 byte mux. It registers the selected byte and presents it downstream with a valid/ready handshake. Per-requester lock lets one source hold the path for a bounded burst before arbitration moves on.

## Interface
- MAX_BURST, 4: maximum consecutive transfers granted to one locked requester (legal 1..15; 1 disables locking).

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  8  request per source; bit i = source i
- lock  input  8  burst request per source; sampled only at accept
- in_data  input  64  source byte i on in_data[8i+7:8i]
- ack  output  8  one-hot pulse: source i's byte accepted this cycle
- out_valid  output  1  out_data/out_src valid
- out_ready  input  1  downstream accepts when high with out_valid
- out_data  output  8  registered selected byte
- out_src  output  3  registered source index (mux select)
- busy  output  1  high whenever state is not IDLE

## Operation
- Registers: state {IDLE, XFER, RELOAD}, ptr[2:0] (highest-priority source), burst_cnt[3:0], out_data, out_src, out_valid.
- Reset (async, rst_n low): state=IDLE, ptr=0, burst_cnt=0, out_data=0, out_src=0, out_valid=0. Because ack and busy are derived from these registers, they are also 0.
- Winner selection is a cyclic search of req starting at ptr: ptr, ptr+1, …, ptr+7, all mod 8. The first set bit wins.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, on the edge: out_src=winner, out_data=in_data[winner], out_valid=1, burst_cnt=1, go to XFER.
- XFER:
  - out_valid=1. out_data and out_src are held stable until accept.
  - Accept is out_valid & out_ready. In the accept cycle, ack[out_src]=1 (combinational from registered state and out_ready). All other ack bits are 0.
  - On accept, if lock[out_src] & (burst_cnt<MAX_BURST): out_valid=0, go to RELOAD.
  - On accept otherwise: out_valid=0, ptr=out_src+1 mod 8, go to IDLE.
  - No accept: stay in XFER. Changes on req, lock or in_data are ignored.
- RELOAD (requester has seen ack and updated in_data):
  - If req[out_src]: out_data=in_data[out_src], burst_cnt+=1, out_valid=1, go to XFER.
  - Else: ptr=out_src+1 mod 8, go to IDLE.
- Requester protocol:
  - Hold req and in_data stable until ack.
  - Drop req, or present the next byte, on the edge after ack.
  - Dropping req while in XFER does not cancel the transfer. The captured byte still completes and ack still pulses.
- out_ready while out_valid=0 is ignored.
- burst_cnt width is 4 bits; MAX_BURST ≤ 15 guarantees no overflow.

## Timing
- Latency from req rising (in IDLE) to out_valid: 1 cycle.
- Single transfers: with out_ready held high, one byte every 2 cycles (XFER, IDLE, XFER, …).
- Locked burst: one byte every 2 cycles (XFER, RELOAD, …). Zero-wait re-arbitration is not supported.
- Backpressure: XFER holds indefinitely. Outputs are bit-stable every cycle until accept.
- ack is high for exactly one cycle per accepted byte, coincident with out_valid & out_ready.
- ptr updates only on leaving a source (the IDLE transitions from XFER and RELOAD). It never changes inside a burst.
- rst_n asserted mid-XFER or mid-RELOAD clears all outputs immediately, without waiting for a clock. The pending byte is discarded with no ack.
- First rising edge after rst_n release behaves as IDLE with ptr=0.

## Test plan
- Reset then simple transfer: rst_n low → all outputs 0. Release, req=8'h01, in_data[7:0]=8'hA5, out_ready=1 → next cycle out_valid=1, out_data=A5, out_src=0, ack=8'h01. The cycle after, out_valid=0 and busy=0.
- Round-robin fairness: req=8'hFF held, each byte=its index, out_ready=1 → out_src sequence 0,1,…,7,0, one grant every 2 cycles, ack one-hot matching out_src.
- Backpressure: req=8'h10, in_data byte4=8'h3C, out_ready=0 for 5 cycles → out_valid=1, out_data=3C, out_src=4 stable, ack=0. Raise out_ready → ack=8'h10 for exactly 1 cycle.
- Locked burst: MAX_BURST=4, ptr=3, req=8'h28, lock=8'h08, source 3 supplies 11,22,33,44,55 (advancing after each ack) → out_data 11,22,33,44 from src 3, then src 5. Byte 55 is not taken until source 3 wins again.
- Pointer wrap: after granting source 6 (ptr=7), req=8'h41 → next grant src 0, then src 6.
- Async reset mid-burst: drop rst_n during XFER of burst byte 2 → out_valid, ack, busy=0 with no clock edge. After release, req=8'h80 → grant src 7 (search from ptr=0).

Source files
------------

// File: rtl/alu_byte_arbiter.sv
// Round-robin arbiter sharing the ALU byte operand path between eight sources.
// Registers the granted byte and hands it downstream over valid/ready, with optional locked bursts.
module alu_byte_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  req,
    input  logic [7:0]  lock,
    input  logic [63:0] in_data,
    output logic [7:0]  ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [2:0]  out_src,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RELOAD
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;
    logic [7:0] out_data_nxt;
    logic [2:0] out_src_nxt;
    logic       out_valid_nxt;
    logic [2:0] winner;
    logic       accept;

    // Walk offsets from farthest to nearest so the source closest to ptr wins.
    always_comb begin
        winner = ptr;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                winner = ptr + 3'(k);
            end
        end
    end

    assign accept = out_valid & out_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        ack = '0;
        if (state == XFER && accept) begin
            ack[out_src] = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        burst_cnt_nxt = burst_cnt;
        out_data_nxt  = out_data;
        out_src_nxt   = out_src;
        out_valid_nxt = out_valid;
        case (state)
            IDLE: begin
                if (|req) begin
                    out_src_nxt   = winner;
                    out_data_nxt  = in_data[{winner, 3'b000} +: 8];
                    out_valid_nxt = 1'b1;
                    burst_cnt_nxt = 4'd1;
                    state_nxt     = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    out_valid_nxt = 1'b0;
                    if (lock[out_src] && (burst_cnt < 4'(MAX_BURST))) begin
                        state_nxt = RELOAD;
                    end else begin
                        ptr_nxt   = out_src + 3'd1;
                        state_nxt = IDLE;
                    end
                end
            end
            RELOAD: begin
                // The locked source had one cycle after its ack to present the next byte or drop req.
                if (req[out_src]) begin
                    out_data_nxt  = in_data[{out_src, 3'b000} +: 8];
                    burst_cnt_nxt = burst_cnt + 4'd1;
                    out_valid_nxt = 1'b1;
                    state_nxt     = XFER;
                end else begin
                    ptr_nxt   = out_src + 3'd1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            burst_cnt <= 4'd0;
            out_data  <= 8'd0;
            out_src   <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            out_data  <= out_data_nxt;
            out_src   <= out_src_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule
